fp_operand_unpacker: RTL and testbench
======================================

FP_OPERAND_UNPACKER -- requirements
Module: fp_operand_unpacker

Interface
REQ-001 The block SHALL have parameter NUM_OPS, default 2, meaning the number of operands unpacked per transaction (legal range 1..4).
REQ-002 The block SHALL have parameter EXP_OUT_W, default 10, meaning the width of each signed output exponent (minimum 10).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the input transaction is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the input this cycle.
REQ-007 The block SHALL have port in_mode_fp, input, 1 bit, meaning 0 = half precision (bits [15:0] of each operand), 1 = single precision.
REQ-008 The block SHALL have port in_ops, input, 32*NUM_OPS bits, meaning operand i in bits [32i+31:32i].
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning the output transaction is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the downstream consumer accepts the output.
REQ-011 The block SHALL have port out_sign, output, NUM_OPS bits, meaning the sign per operand.
REQ-012 The block SHALL have port out_exp, output, EXP_OUT_W*NUM_OPS bits, meaning the two's-complement exponent per operand, single-precision bias (127).
REQ-013 The block SHALL have port out_mant, output, 24*NUM_OPS bits, meaning the significand per operand {hidden bit, 23-bit fraction}.
REQ-014 The block SHALL have ports out_is_nan, out_is_snan, out_is_inf, out_is_zero, out_is_denorm, each output, NUM_OPS bits, meaning the per-operand class flags.
REQ-015 The block SHALL have port out_mode_fp, output, 1 bit, meaning the mode latched with the transaction.

Function
REQ-016 A transfer SHALL occur on any edge where valid and ready are both high; the block SHALL capture in_mode_fp and in_ops only on an input transfer.
REQ-017 The block SHALL have two register stages: S1 registers extracted fields, class flags and the leading-zero count of the fraction; S2 registers the normalised outputs.
REQ-018 An accepted input SHALL appear with out_valid high exactly 2 cycles after acceptance when out_ready is held high.
REQ-019 Each stage SHALL load when it is empty or when its contents move on this cycle; in_ready SHALL equal !s1_valid | s1_advance, so the block sustains 1 transaction/cycle.
REQ-020 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable; no transaction SHALL be dropped or duplicated, and order SHALL be preserved.
REQ-021 Half mode: exponent field = op[14:10], fraction = {op[9:0],13'b0}, sign = op[15], op[31:16] ignored; single mode: op[30:23], op[22:0], op[31].
REQ-022 Classes: zero = exp field 0 and frac 0; denorm = exp field 0 and frac≠0; inf = exp field all-ones and frac 0; nan = exp field all-ones and frac≠0; snan = nan and frac MSB (bit 22 after extension) 0.
REQ-023 For a normal operand, out_mant SHALL be {1,frac} and out_exp SHALL be the exp field in single mode, or the exp field +112 in half mode.
REQ-024 For a denorm operand, shift = lzc23(frac)+1; out_mant = {0,frac}<<shift, so that bit 23 = 1; out_exp = E1 - shift, where E1 = 1 (single) or 113 (half); the result may be negative.
REQ-025 For a zero operand, out_exp = 0 and out_mant = 0.
REQ-026 For an inf or nan operand, out_exp = 255 and out_mant = {0,frac}, with the payload preserved.
REQ-027 Exactly one of nan/inf/zero/denorm/(none) SHALL be set per operand; snan SHALL imply nan.

Reset
REQ-028 While rst=1 at an edge, both stage valids SHALL clear and all out_* registers SHALL reset to 0; in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-029 Transactions in flight at reset SHALL be discarded without ever asserting out_valid.

Verification
REQ-030 Scenario: mode=1, op0=0x3F800000, out_ready=1 -> 2 cycles later out_exp0=0x07F, out_mant0=0x800000, all flags 0.
REQ-031 Scenario: mode=0, op0=0xDEAD3C00 -> out_sign0=0, out_exp0=127, out_mant0=0x800000, upper half ignored.
REQ-032 Scenario: mode=1, op0=0x00000001; mode=0, op0=0x0001 -> out_exp=-22 (0x3EA), mant 0x800000, denorm=1; and out_exp=103, mant 0x800000, denorm=1.
REQ-033 Scenario: mode=1, op0=0x7FA00000, op1=0xFF800000 -> op0: nan=1, snan=1, exp 255, mant 0x200000; op1: inf=1, sign=1.
REQ-034 Scenario: issue 4 back-to-back transactions with out_ready=0 for 5 cycles -> in_ready drops after 2 are held, outputs stable, then all 4 drain in order, 1 per cycle.
REQ-035 Scenario: assert rst for 1 cycle with 2 transactions in flight -> out_valid never asserts for them, and all outputs are 0 the next cycle.

Source files
------------

// File: rtl/fp_operand_unpacker.sv
// Two-stage IEEE operand unpacker: classifies half/single operands and normalises
// them to a common {sign, signed exponent (bias 127), 24-bit significand} form.
module fp_operand_unpacker #(
   parameter int NUM_OPS   = 2,
   parameter int EXP_OUT_W = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_mode_fp,
   input  logic [32*NUM_OPS-1:0]        in_ops,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_OPS-1:0]           out_sign,
   output logic [EXP_OUT_W*NUM_OPS-1:0] out_exp,
   output logic [24*NUM_OPS-1:0]        out_mant,
   output logic [NUM_OPS-1:0]           out_is_nan,
   output logic [NUM_OPS-1:0]           out_is_snan,
   output logic [NUM_OPS-1:0]           out_is_inf,
   output logic [NUM_OPS-1:0]           out_is_zero,
   output logic [NUM_OPS-1:0]           out_is_denorm,
   output logic                         out_mode_fp
);

   function automatic logic [4:0] lzc23(input logic [22:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd23;
      found = 1'b0;
      for (int b = 22; b >= 0; b--) begin
         if (!found && v[b]) begin
            n     = 5'(22 - b);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   logic s1_valid_q, s1_mode_q, s2_valid_q;
   logic s1_advance, s2_load;

   logic [NUM_OPS-1:0]       s1_sign_q, s1_sign_d;
   logic [NUM_OPS-1:0]       s1_nan_q, s1_nan_d, s1_snan_q, s1_snan_d;
   logic [NUM_OPS-1:0]       s1_inf_q, s1_inf_d, s1_zero_q, s1_zero_d;
   logic [NUM_OPS-1:0]       s1_den_q, s1_den_d;
   logic [NUM_OPS-1:0]       exp_max, exp_zero, frac_nz;
   logic [NUM_OPS-1:0][7:0]  s1_exp_q, s1_exp_d;
   logic [NUM_OPS-1:0][22:0] s1_frac_q, s1_frac_d;
   logic [NUM_OPS-1:0][4:0]  s1_lzc_q, s1_lzc_d;

   logic [NUM_OPS-1:0][EXP_OUT_W-1:0] out_exp_q, s2_exp_d;
   logic [NUM_OPS-1:0][23:0]          out_mant_q, s2_mant_d;
   logic [NUM_OPS-1:0][5:0]           den_shift;
   logic [NUM_OPS-1:0]                out_sign_q, out_nan_q, out_snan_q;
   logic [NUM_OPS-1:0]                out_inf_q, out_zero_q, out_den_q;
   logic                              out_mode_q;

   assign s2_load    = ~s2_valid_q | out_ready;
   assign s1_advance = s1_valid_q & s2_load;
   assign in_ready   = ~s1_valid_q | s1_advance;

   // Half-precision fields are zero-extended into the single-precision layout
   always_comb begin
      s1_sign_d = '0;
      s1_exp_d  = '0;
      s1_frac_d = '0;
      s1_nan_d  = '0;
      s1_snan_d = '0;
      s1_inf_d  = '0;
      s1_zero_d = '0;
      s1_den_d  = '0;
      s1_lzc_d  = '0;
      exp_max   = '0;
      exp_zero  = '0;
      frac_nz   = '0;
      for (int i = 0; i < NUM_OPS; i++) begin
         if (in_mode_fp) begin
            s1_sign_d[i] = in_ops[32*i+31];
            s1_exp_d[i]  = in_ops[32*i+23 +: 8];
            s1_frac_d[i] = in_ops[32*i +: 23];
            exp_max[i]   = &in_ops[32*i+23 +: 8];
         end else begin
            s1_sign_d[i] = in_ops[32*i+15];
            s1_exp_d[i]  = {3'b000, in_ops[32*i+10 +: 5]};
            s1_frac_d[i] = {in_ops[32*i +: 10], 13'b0};
            exp_max[i]   = &in_ops[32*i+10 +: 5];
         end
         exp_zero[i]  = (s1_exp_d[i] == 8'd0);
         frac_nz[i]   = |s1_frac_d[i];
         s1_zero_d[i] = exp_zero[i] & ~frac_nz[i];
         s1_den_d[i]  = exp_zero[i] & frac_nz[i];
         s1_inf_d[i]  = exp_max[i] & ~frac_nz[i];
         s1_nan_d[i]  = exp_max[i] & frac_nz[i];
         s1_snan_d[i] = exp_max[i] & frac_nz[i] & ~s1_frac_d[i][22];
         s1_lzc_d[i]  = lzc23(s1_frac_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_sign_q  <= '0;
         s1_exp_q   <= '0;
         s1_frac_q  <= '0;
         s1_nan_q   <= '0;
         s1_snan_q  <= '0;
         s1_inf_q   <= '0;
         s1_zero_q  <= '0;
         s1_den_q   <= '0;
         s1_lzc_q   <= '0;
      end else begin
         if (in_ready) s1_valid_q <= in_valid;
         if (in_ready && in_valid) begin
            s1_mode_q <= in_mode_fp;
            s1_sign_q <= s1_sign_d;
            s1_exp_q  <= s1_exp_d;
            s1_frac_q <= s1_frac_d;
            s1_nan_q  <= s1_nan_d;
            s1_snan_q <= s1_snan_d;
            s1_inf_q  <= s1_inf_d;
            s1_zero_q <= s1_zero_d;
            s1_den_q  <= s1_den_d;
            s1_lzc_q  <= s1_lzc_d;
         end
      end
   end

   // Denormals shift until the leading one lands in the hidden-bit position
   always_comb begin
      s2_exp_d  = '0;
      s2_mant_d = '0;
      den_shift = '0;
      for (int i = 0; i < NUM_OPS; i++) begin
         if (s1_zero_q[i]) begin
            s2_exp_d[i]  = '0;
            s2_mant_d[i] = '0;
         end else if (s1_nan_q[i] || s1_inf_q[i]) begin
            s2_exp_d[i]  = EXP_OUT_W'(255);
            s2_mant_d[i] = {1'b0, s1_frac_q[i]};
         end else if (s1_den_q[i]) begin
            den_shift[i] = {1'b0, s1_lzc_q[i]} + 6'd1;
            s2_mant_d[i] = {1'b0, s1_frac_q[i]} << den_shift[i];
            s2_exp_d[i]  = (s1_mode_q ? EXP_OUT_W'(1) : EXP_OUT_W'(113))
                           - EXP_OUT_W'(den_shift[i]);
         end else begin
            s2_mant_d[i] = {1'b1, s1_frac_q[i]};
            s2_exp_d[i]  = EXP_OUT_W'(s1_exp_q[i])
                           + (s1_mode_q ? EXP_OUT_W'(0) : EXP_OUT_W'(112));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         out_mode_q <= 1'b0;
         out_sign_q <= '0;
         out_exp_q  <= '0;
         out_mant_q <= '0;
         out_nan_q  <= '0;
         out_snan_q <= '0;
         out_inf_q  <= '0;
         out_zero_q <= '0;
         out_den_q  <= '0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_mode_q <= s1_mode_q;
            out_sign_q <= s1_sign_q;
            out_exp_q  <= s2_exp_d;
            out_mant_q <= s2_mant_d;
            out_nan_q  <= s1_nan_q;
            out_snan_q <= s1_snan_q;
            out_inf_q  <= s1_inf_q;
            out_zero_q <= s1_zero_q;
            out_den_q  <= s1_den_q;
         end
      end
   end

   assign out_valid     = s2_valid_q;
   assign out_mode_fp   = out_mode_q;
   assign out_sign      = out_sign_q;
   assign out_exp       = out_exp_q;
   assign out_mant      = out_mant_q;
   assign out_is_nan    = out_nan_q;
   assign out_is_snan   = out_snan_q;
   assign out_is_inf    = out_inf_q;
   assign out_is_zero   = out_zero_q;
   assign out_is_denorm = out_den_q;

endmodule

// File: tb/tb_fp_operand_unpacker.sv
// Scoreboard bench for fp_operand_unpacker (NUM_OPS=2, EXP_OUT_W=10).
module tb_fp_operand_unpacker;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_mode_fp;
   logic        out_valid, out_ready, out_mode_fp;
   logic [63:0] in_ops;
   logic [1:0]  out_sign, out_is_nan, out_is_snan, out_is_inf, out_is_zero, out_is_denorm;
   logic [19:0] out_exp;
   logic [47:0] out_mant;

   always #5 clk = ~clk;

   fp_operand_unpacker #(.NUM_OPS(2), .EXP_OUT_W(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode_fp(in_mode_fp), .in_ops(in_ops), .out_valid(out_valid),
      .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
      .out_mant(out_mant), .out_is_nan(out_is_nan), .out_is_snan(out_is_snan),
      .out_is_inf(out_is_inf), .out_is_zero(out_is_zero),
      .out_is_denorm(out_is_denorm), .out_mode_fp(out_mode_fp)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [80:0] sb_q[$];
   logic [80:0] drv_exp;
   bit          done;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Per-operand {sign, exp[9:0], mant[23:0], nan, snan, inf, zero, denorm}
   function automatic logic [39:0] model_op(input logic mode, input logic [31:0] op);
      int          e, emax, ex;
      logic [22:0] f;
      logic [23:0] m;
      logic        s, nan, snan, inf, zero, den;
      nan = 0; snan = 0; inf = 0; zero = 0; den = 0;
      if (mode) begin
         s = op[31]; e = int'(op[30:23]); f = op[22:0]; emax = 255;
      end else begin
         s = op[15]; e = int'(op[14:10]); f = {op[9:0], 13'b0}; emax = 31;
      end
      if (e == 0 && f == 0) begin
         zero = 1; ex = 0; m = 0;
      end else if (e == 0) begin
         den = 1; m = {1'b0, f}; ex = mode ? 1 : 113;
         while (m[23] == 1'b0) begin
            m = m << 1;
            ex--;
         end
      end else if (e == emax) begin
         ex = 255; m = {1'b0, f};
         if (f != 0) begin
            nan = 1; snan = !f[22];
         end else inf = 1;
      end else begin
         m = {1'b1, f}; ex = mode ? e : e + 112;
      end
      return {s, ex[9:0], m, nan, snan, inf, zero, den};
   endfunction

   function automatic logic [80:0] model_txn(input logic mode, input logic [63:0] ops);
      return {mode, model_op(mode, ops[63:32]), model_op(mode, ops[31:0])};
   endfunction

   function automatic logic [80:0] obs();
      return {out_mode_fp,
              out_sign[1], out_exp[19:10], out_mant[47:24], out_is_nan[1],
              out_is_snan[1], out_is_inf[1], out_is_zero[1], out_is_denorm[1],
              out_sign[0], out_exp[9:0], out_mant[23:0], out_is_nan[0],
              out_is_snan[0], out_is_inf[0], out_is_zero[0], out_is_denorm[0]};
   endfunction

   function automatic logic [31:0] gen_op();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 5))
         0: r[30:23] = 8'h00;
         1: r[30:23] = 8'hFF;
         2: r[14:10] = 5'h00;
         3: r[14:10] = 5'h1F;
         4: begin r[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00; r[22:0] = '0; end
         default: ;
      endcase
      if ($urandom_range(0, 5) == 0) r[9:0] = '0;
      return r;
   endfunction

   // Compare every visible output against the queue head; pop only on a transfer
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (sb_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
            else begin
               chk("out_txn", obs(), sb_q[0]);
               if (out_ready) void'(sb_q.pop_front());
            end
         end
         if (in_valid && in_ready) sb_q.push_back(drv_exp);
      end
   end

   task automatic send(input logic mode, input logic [63:0] ops, input logic [80:0] exp);
      int cyc;
      bit acc;
      cyc = 0;
      acc = 0;
      drv_exp    = exp;
      in_mode_fp = mode;
      in_ops     = ops;
      in_valid   = 1'b1;
      while (!acc && cyc < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         cyc++;
      end
      #1;
      in_valid = 1'b0;
      chk("send_accept", acc, 1'b1);
   endtask

   task automatic send_m(input logic mode, input logic [63:0] ops);
      send(mode, ops, model_txn(mode, ops));
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while (sb_q.size() != 0 && c < 300) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk("drain_empty", sb_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_mode_fp = 1'b0; in_ops = '0;
      out_ready = 1'b1; drv_exp = '0; done = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_outputs", obs(), 81'd0);
      @(posedge clk); #1;

      // single 1.0, with latency probe
      send(1'b1, {32'h0, 32'h3F800000},
           {1'b1, model_op(1'b1, 32'h0), {1'b0, 10'h07F, 24'h800000, 5'b00000}});
      chk("lat_early", out_valid, 1'b0);
      @(posedge clk); #1;
      chk("lat_2cyc", out_valid, 1'b1);

      // half 1.0, upper half ignored
      send(1'b0, {32'h12345678, 32'hDEAD3C00},
           {1'b0, model_op(1'b0, 32'h12345678), {1'b0, 10'd127, 24'h800000, 5'b00000}});
      // smallest denormals
      send(1'b1, {32'h0, 32'h00000001},
           {1'b1, model_op(1'b1, 32'h0), {1'b0, 10'h3EA, 24'h800000, 5'b00001}});
      send(1'b0, {32'h0, 32'h00000001},
           {1'b0, model_op(1'b0, 32'h0), {1'b0, 10'd103, 24'h800000, 5'b00001}});
      // sNaN and -inf
      send(1'b1, {32'hFF800000, 32'h7FA00000},
           {1'b1, {1'b1, 10'd255, 24'h000000, 5'b00100},
                  {1'b0, 10'd255, 24'h200000, 5'b11000}});
      // half max normal / qNaN, single largest denorm / max normal
      send_m(1'b0, {32'h00007E01, 32'h00007BFF});
      send_m(1'b1, {32'h7F7FFFFF, 32'h807FFFFF});
      wait_drain();

      // four back-to-back under a 5-cycle stall
      out_ready = 1'b0;
      fork
         begin
            send_m(1'b1, {32'h40490FDB, 32'h00400000});
            send_m(1'b0, {32'h0000FC00, 32'h00000200});
            send_m(1'b1, {32'h7FC00001, 32'h80000000});
            send_m(1'b0, {32'hAAAA8000, 32'h00007D00});
         end
         begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("drain_rate", out_valid, 1'b1);
            end
         end
      join
      wait_drain();

      // random traffic with random backpressure
      fork
         begin
            for (int t = 0; t < 40; t++) begin
               logic        m;
               logic [63:0] ops;
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               m   = ($urandom_range(0, 1) != 0);
               ops = {gen_op(), gen_op()};
               send_m(m, ops);
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // reset with two transactions held in the pipe
      out_ready = 1'b0;
      send_m(1'b1, {32'h3F800000, 32'h40000000});
      send_m(1'b0, {32'h00003C00, 32'h00004000});
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("post_rst_valid", out_valid, 1'b0);
      chk("post_rst_outputs", obs(), 81'd0);
      chk("post_rst_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("no_resurrect", out_valid, 1'b0);

      send_m(1'b1, {32'hC2F60000, 32'h00000400});
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
